// File: rtl/keypad_scan_fifo_if.sv
// keypad_scan_fifo_if
//   Bus between the keypad scanner and its neighbours: the keypad matrix
//   (kprow out, kpcol in) and the downstream key consumer (FIFO read side).
//
//   Handshake: key_valid is high whenever the FIFO holds an entry, and key_code
//   then shows the oldest entry. A pop happens on a clk edge where
//   key_valid && key_rd. key_rd while key_valid = 0 has no effect. key_code
//   reads 0 while the FIFO is empty.
//
//   dbg_state exposes the scanner FSM: 0 = IDLE, 1 = DEB_PRESS, 2 = HELD,
//   3 = DEB_REL.
//
//   Modports: slave = scanner side, master = keypad + consumer side.
interface keypad_scan_fifo_if #(
  parameter int NROWS = 4,
  parameter int NCOLS = 6,
  parameter int KW    = $clog2(NROWS * NCOLS)
);
  logic [NCOLS-1:0] kpcol;
  logic [NROWS-1:0] kprow;
  logic             key_rd;
  logic             key_valid;
  logic [KW-1:0]    key_code;
  logic             overflow;
  logic             ovf_clr;
  logic [1:0]       dbg_state;

  modport slave (
    input  kpcol, key_rd, ovf_clr,
    output kprow, key_valid, key_code, overflow, dbg_state
  );

  modport master (
    output kpcol, key_rd, ovf_clr,
    input  kprow, key_valid, key_code, overflow, dbg_state
  );
endinterface

// File: rtl/keypad_scan_fifo.sv
// keypad_scan_fifo
//   Row-strobed keypad scanner with debounce, ghost/multi-key rejection and a
//   first-word-fall-through key FIFO.
//
//   Ports:
//     clk    system clock
//     reset  asynchronous, active-high
//     bus    keypad_scan_fifo_if.slave: kpcol in, kprow out, key_rd in,
//            key_valid/key_code out, overflow out (sticky), ovf_clr in,
//            dbg_state out (FSM state)
//
//   Optional feature: define KEYPAD_AUTOREPEAT_EN to re-push the held key
//   after REPEAT_DELAY full scans and then every REPEAT_RATE full scans.
//   Without it each press produces exactly one push.
//
//   Key code = row * NCOLS + col. NROWS >= 2, DEBOUNCE_SCANS >= 2,
//   FIFO_DEPTH a power of 2 and >= 2.
module keypad_scan_fifo #(
  parameter int NROWS          = 4,
  parameter int NCOLS          = 6,
  parameter int SCAN_DIV       = 5000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4
`ifdef KEYPAD_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY   = 125,
  parameter int REPEAT_RATE    = 25
`endif
) (
  input logic clk,
  input logic reset,
  keypad_scan_fifo_if.slave bus
);

  localparam int KW = $clog2(NROWS * NCOLS);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int RW = $clog2(NROWS);
  localparam int CW = (NCOLS > 1) ? $clog2(NCOLS) : 1;
  localparam int NW = $clog2(DEBOUNCE_SCANS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, DEB_PRESS = 2'd1, HELD = 2'd2, DEB_REL = 2'd3} state_e;

  // ---------------- scan divider and row strobe ----------------
  logic [DW-1:0]    div_q;
  logic [RW-1:0]    row_q;
  logic [NROWS-1:0] kprow_q;
  logic             tick;

  assign tick = (div_q == DW'(SCAN_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      row_q   <= '0;
      kprow_q <= NROWS'(1);
    end else begin
      div_q <= tick ? '0 : div_q + 1'b1;
      // kpcol is judged during the tick; the strobe moves on at its closing edge.
      if (tick) begin
        row_q   <= (row_q == RW'(NROWS - 1)) ? '0 : row_q + 1'b1;
        kprow_q <= {kprow_q[NROWS-2:0], kprow_q[NROWS-1]};
      end
    end
  end

  // ---------------- sample classification ----------------
  logic [CW:0]   n_ones;
  logic [CW-1:0] hit_col;
  logic          single;

  always_comb begin
    n_ones  = '0;
    hit_col = '0;
    for (int i = 0; i < NCOLS; i++) begin
      if (bus.kpcol[i]) begin
        n_ones  = n_ones + 1'b1;
        hit_col = CW'(i);
      end
    end
  end

  // Two or more returns in one row is a ghost/multi pattern and reads as no key.
  assign single = (n_ones == (CW + 1)'(1));

  // ---------------- debounce FSM ----------------
  state_e        state_q;
  logic [RW-1:0] cand_row_q;
  logic [CW-1:0] cand_col_q;
  logic [NW-1:0] cnt_q;
  logic [NW-1:0] cnt_inc;
  logic          at_row;
  logic          match;
  logic          press_push;
  logic          rep_fire;
  logic          push_w;
  logic [KW-1:0] push_code;

  assign at_row     = (row_q == cand_row_q);
  assign match      = single && (hit_col == cand_col_q);
  assign cnt_inc    = cnt_q + 1'b1;
  assign press_push = tick && (state_q == DEB_PRESS) && at_row && match &&
                      (cnt_inc == NW'(DEBOUNCE_SCANS));
  assign push_w     = press_push || rep_fire;
  assign push_code  = KW'(int'(cand_row_q) * NCOLS + int'(cand_col_q));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cand_row_q <= '0;
      cand_col_q <= '0;
      cnt_q      <= '0;
    end else if (tick) begin
      case (state_q)
        IDLE: begin
          if (single) begin
            cand_row_q <= row_q;
            cand_col_q <= hit_col;
            cnt_q      <= NW'(1);
            state_q    <= DEB_PRESS;
          end
        end
        DEB_PRESS: begin
          if (at_row) begin
            if (!match) begin
              cnt_q   <= '0;
              state_q <= IDLE;
            end else if (press_push) begin
              cnt_q   <= '0;
              state_q <= HELD;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        HELD: begin
          if (at_row && !match) begin
            cnt_q   <= NW'(1);
            state_q <= DEB_REL;
          end
        end
        DEB_REL: begin
          // Anything but the locked key (nothing, another key, a ghost) counts as released.
          if (at_row) begin
            if (match) begin
              cnt_q   <= '0;
              state_q <= HELD;
            end else if (cnt_inc == NW'(DEBOUNCE_SCANS)) begin
              cnt_q   <= '0;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  // One locked-row visit per full scan, so visits while HELD count scans.
  // DEB_REL leaves the count untouched; only IDLE restarts it.
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPW  = $clog2(RMAX + 1);

  logic [RPW-1:0] rep_cnt_q;
  logic           rep_armed_q;
  logic           held_visit;

  assign held_visit = tick && (state_q == HELD) && at_row && match;
  assign rep_fire   = held_visit &&
                      ((rep_cnt_q + 1'b1) == (rep_armed_q ? RPW'(REPEAT_RATE) : RPW'(REPEAT_DELAY)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
    end else if (state_q == IDLE) begin
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
    end else if (held_visit) begin
      if (rep_fire) begin
        rep_cnt_q   <= '0;
        rep_armed_q <= 1'b1;
      end else begin
        rep_cnt_q <= rep_cnt_q + 1'b1;
      end
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // ---------------- key FIFO ----------------
  logic [KW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   fcnt_q;
  logic          ovf_q;
  logic          pop;
  logic          full;
  logic          push_ok;
  logic          ovf_set;

  assign pop     = bus.key_rd && (fcnt_q != '0);
  assign full    = (fcnt_q == (AW + 1)'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok = push_w && (!full || pop);
  assign ovf_set = push_w && full && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fcnt_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   fcnt_q <= fcnt_q + 1'b1;
        2'b01:   fcnt_q <= fcnt_q - 1'b1;
        default: fcnt_q <= fcnt_q;
      endcase
      if (ovf_set)          ovf_q <= 1'b1;
      else if (bus.ovf_clr) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= push_code;
  end

  assign bus.kprow     = kprow_q;
  assign bus.key_valid = (fcnt_q != '0);
  assign bus.key_code  = (fcnt_q != '0) ? mem_q[rd_q] : '0;
  assign bus.overflow  = ovf_q;
  assign bus.dbg_state = state_q;

endmodule
